pwm_generator: RTL and testbench

PWM_GENERATOR -- requirements
Module: pwm_generator

---
 rtl/pwm_generator.sv | 45 ++++
 tb/tb_pwm_generator.sv | 137 +++++++++++++
 2 files changed

// File: rtl/pwm_generator.sv
// Free-running PWM generator: a WIDTH-bit period counter compared against a
// duty value that is only reloaded at period boundaries, so pulses never glitch.
module pwm_generator #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] duty,
    output logic             pwm_out
);

    logic [WIDTH-1:0] cnt_q;
    logic [WIDTH-1:0] cnt_d;
    logic [WIDTH-1:0] duty_q;
    logic [WIDTH-1:0] duty_d;
    logic             pwm_q;
    logic             pwm_d;
    logic             period_end;

    assign period_end = (cnt_q == {WIDTH{1'b1}});

    always_comb begin
        cnt_d  = cnt_q + WIDTH'(1);
        duty_d = period_end ? duty : duty_q;
        // Strict less-than: duty of all-ones still leaves one low clock per period.
        pwm_d  = (cnt_q < duty_q);
    end

    // NOTE: non-blocking assignments keep every register reading pre-edge values,
    // which is what gives the one-clock counter-to-output latency.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q  <= '0;
            duty_q <= duty;
            pwm_q  <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            duty_q <= duty_d;
            pwm_q  <= pwm_d;
        end
    end

    assign pwm_out = pwm_q;

endmodule

// File: tb/tb_pwm_generator.sv
// Self-checking bench for pwm_generator: per-period waveform model compared every
// cycle, plus measured high-time per period against hand-computed duty values.
module tb_pwm_generator;

    localparam int W      = 8;
    localparam int PERIOD = 1 << W;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic [W-1:0] duty = '0;
    logic         pwm_out;

    int checks = 0;
    int errors = 0;

    pwm_generator #(.WIDTH(W)) dut (
        .clk     (clk),
        .reset   (reset),
        .duty    (duty),
        .pwm_out (pwm_out)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
        end
    endtask

    function automatic int bit_val(input logic b);
        return (b === 1'b1) ? 1 : ((b === 1'b0) ? 0 : 2);
    endfunction

    // Model: edges elapsed in the current period and the duty latched for it.
    // Edge k (1..PERIOD) of a period is high exactly when k <= latched duty.
    int m_edge  = 0;
    int m_duty  = 0;
    int m_pwm   = 0;
    bit m_valid = 1'b0;

    always @(posedge clk) begin
        if (reset) begin
            m_edge  = 0;
            m_duty  = int'(duty);
            m_pwm   = 0;
            m_valid = 1'b1;
        end else begin
            m_edge = m_edge + 1;
            m_pwm  = (m_edge <= m_duty) ? 1 : 0;
            if (m_edge == PERIOD) begin
                m_edge = 0;
                m_duty = int'(duty);
            end
        end
    end

    always @(negedge clk) begin
        if (m_valid)
            check("model", bit_val(pwm_out), m_pwm);
    end

    task automatic apply_reset(input int n, input logic [W-1:0] d);
        @(negedge clk);
        reset = 1'b1;
        duty  = d;
        repeat (n) @(negedge clk);
        check("reset_low", bit_val(pwm_out), 0);
        reset = 1'b0;
    endtask

    // Samples one full period starting right after a period start; optionally
    // rewrites duty after the edge that leaves the counter at chg_at.
    task automatic measure_period(input string name, input int exp_high,
                                  input int chg_at, input logic [W-1:0] new_duty);
        int ones = 0;
        int lead = 0;
        bit run  = 1'b1;
        for (int i = 1; i <= PERIOD; i++) begin
            @(negedge clk);
            if (pwm_out === 1'b1) begin
                ones++;
                if (run) lead++;
            end else begin
                run = 1'b0;
            end
            if (i == chg_at) duty = new_duty;
        end
        check({name, "_high"}, ones, exp_high);
        check({name, "_lead"}, lead, exp_high);
    endtask

    initial begin
        // Zero duty: silent output over 1024 clocks.
        apply_reset(2, 8'd0);
        repeat (4) measure_period("duty0", 0, 0, 8'd0);

        // Half duty held through reset.
        apply_reset(2, 8'd128);
        repeat (4) measure_period("duty128", 128, 0, 8'd128);

        // Mid-period change only takes effect at the next boundary.
        apply_reset(2, 8'd64);
        measure_period("chg_old64", 64, 10, 8'd192);
        measure_period("chg_new192", 192, 0, 8'd192);

        // Extremes, second one loaded through a boundary rather than reset.
        apply_reset(1, 8'd255);
        measure_period("duty255_a", 255, 0, 8'd255);
        measure_period("duty255_b", 255, 100, 8'd1);
        measure_period("duty1_a", 1, 0, 8'd1);
        measure_period("duty1_b", 1, 0, 8'd1);

        // Reset asserted mid-period restarts the period.
        apply_reset(2, 8'd200);
        repeat (50) @(negedge clk);
        check("pre_midreset_high", bit_val(pwm_out), 1);
        reset = 1'b1;
        @(negedge clk);
        check("midreset_low", bit_val(pwm_out), 0);
        reset = 1'b0;
        measure_period("after_midreset", 200, 0, 8'd200);

        // Sweep every 17th duty, each loaded at a boundary mid-stream.
        for (int d = 0; d <= 255; d += 17) begin
            measure_period("sweep_prev", (d == 0) ? 200 : d - 17, 128, W'(d));
            measure_period("sweep_a", d, 0, W'(d));
            measure_period("sweep_b", d, 0, W'(d));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
